// File: rtl/pipeline_run_ctl_pkg.sv
// Shared encodings for the pipeline run/halt/step sequencer.
// Hazard and debug logic import this package to decode o_state.
package pipeline_run_ctl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_BP   = 2'd3
    } run_state_e;

    // A step press with a zero count still advances the pipeline by this many cycles.
    localparam int unsigned STEP_ZERO_LOAD = 1;

endpackage

// File: rtl/pipeline_run_ctl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, and a rising-edge press pulse.
// Latency: a press_vld pulse follows a clean raw rising edge by 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; press_vld is a single-cycle pulse and is never held.
module pipeline_run_ctl_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic btn_raw,
    output logic press_vld
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             lvl_q;
    logic [CNT_W-1:0] cnt_q;
    logic             settle;

    // The sample taken this cycle is the last one needed, so the level flips at this edge.
    assign settle    = (sync_q2 != lvl_q) && (cnt_q == CNT_LAST);
    assign press_vld = settle && sync_q2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == lvl_q) begin
                cnt_q <= '0;
            end else if (settle) begin
                lvl_q <= sync_q2;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_run_ctl.sv
// Run/halt/step/breakpoint sequencer driving the datapath clock enable from two debounced buttons.
// Latency: o_clk_en is Mealy on the breakpoint compare; button presses act 2 + DEBOUNCE_CYCLES after the raw edge.
// Backpressure: none; o_clk_en is the datapath's only throttle and is forced low during reset.
module pipeline_run_ctl
    import pipeline_run_ctl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PC_W            = 64,
    parameter int STEP_W          = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_btn_run,
    input  logic              i_btn_step,
    input  logic [STEP_W-1:0] i_step_count,
    input  logic              i_bp_en,
    input  logic [PC_W-1:0]   i_bp_addr,
    input  logic [PC_W-1:0]   i_pc_f,
    input  logic              i_halt_req,
    output logic              o_clk_en,
    output logic [1:0]        o_state,
    output logic              o_bp_hit,
    output logic [31:0]       o_cycle_cnt
);

    run_state_e        state_q, state_nxt;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_nxt;
    logic              bp_hit_q, bp_hit_nxt;
    logic              suppress_q, suppress_nxt;
    logic [31:0]       cycle_cnt_q;
    logic              run_press;
    logic              step_press;
    logic              bp_match;
    logic              clk_en;
    logic [STEP_W-1:0] step_load;

    pipeline_run_ctl_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce_run (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .btn_raw  (i_btn_run),
        .press_vld(run_press)
    );

    pipeline_run_ctl_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce_step (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .btn_raw  (i_btn_step),
        .press_vld(step_press)
    );

    // Suppress masks the compare for the first resumed cycle so a resume can leave the breakpoint PC.
    assign bp_match  = i_bp_en && (i_pc_f == i_bp_addr) && !suppress_q;
    assign step_load = (i_step_count == '0) ? STEP_W'(STEP_ZERO_LOAD) : i_step_count;

    always_comb begin
        clk_en = 1'b0;
        if (!i_rst) begin
            if (state_q == ST_RUN && !bp_match) begin
                clk_en = 1'b1;
            end
            if (state_q == ST_STEP) begin
                clk_en = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state_q;
        step_cnt_nxt = step_cnt_q;
        bp_hit_nxt   = bp_hit_q;
        suppress_nxt = suppress_q;

        if (state_q == ST_RUN && clk_en) begin
            suppress_nxt = 1'b0;
        end

        case (state_q)
            ST_HALT, ST_BP: begin
                // Run takes priority over a step press landing in the same cycle.
                if (run_press) begin
                    state_nxt    = ST_RUN;
                    suppress_nxt = 1'b1;
                    bp_hit_nxt   = 1'b0;
                end else if (step_press) begin
                    state_nxt    = ST_STEP;
                    step_cnt_nxt = step_load;
                    bp_hit_nxt   = 1'b0;
                end
            end
            ST_RUN: begin
                if (i_halt_req || run_press) begin
                    state_nxt = ST_HALT;
                end else if (bp_match) begin
                    state_nxt  = ST_BP;
                    bp_hit_nxt = 1'b1;
                end
            end
            ST_STEP: begin
                if (i_halt_req || run_press) begin
                    state_nxt    = ST_HALT;
                    step_cnt_nxt = '0;
                end else begin
                    step_cnt_nxt = step_cnt_q - 1'b1;
                    if (step_cnt_q == STEP_W'(1)) begin
                        state_nxt = ST_HALT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_HALT;
            step_cnt_q  <= '0;
            bp_hit_q    <= 1'b0;
            suppress_q  <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q    <= state_nxt;
            step_cnt_q <= step_cnt_nxt;
            bp_hit_q   <= bp_hit_nxt;
            suppress_q <= suppress_nxt;
            if (clk_en) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
        end
    end

    assign o_clk_en    = clk_en;
    assign o_state     = state_q;
    assign o_bp_hit    = bp_hit_q;
    assign o_cycle_cnt = cycle_cnt_q;

endmodule

// File: doc/pipeline_run_ctl.md
Name: pipeline_run_ctl

Overview:
Run/halt/step sequencer for the pipeline clock enable, replacing the single-button toggle flop at pipeline top. It debounces two board buttons and drives the datapath clock-enable in four modes: halted, free-run, N-cycle step, and stopped-at-breakpoint. Its `o_clk_en` feeds `i_clk_en` of the datapath. The fetch PC is compared against a programmable breakpoint address.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required before the debounced level changes. Must be ≥1.
- PC_W, 64: width of PC and breakpoint address.
- STEP_W, 8: width of the step-count input.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_btn_run  in  1  raw run/halt button, asynchronous, bouncing.
- i_btn_step  in  1  raw step button, asynchronous, bouncing.
- i_step_count  in  STEP_W  enabled cycles per step press; 0 is treated as 1.
- i_bp_en  in  1  breakpoint enable.
- i_bp_addr  in  PC_W  breakpoint address.
- i_pc_f  in  PC_W  current fetch-stage PC.
- i_halt_req  in  1  synchronous halt request (e.g. ebreak retire), level.
- o_clk_en  out  1  datapath clock enable.
- o_state  out  2  FSM state: 0 HALT, 1 RUN, 2 STEP, 3 BP.
- o_bp_hit  out  1  sticky breakpoint flag.
- o_cycle_cnt  out  32  count of cycles with o_clk_en=1.

Behaviour:
- Reset, i_rst high at a clock edge:
  - state=HALT, step counter=0, o_bp_hit=0, o_cycle_cnt=0, suppress flag=0.
  - Debounced levels=0; synchronizers=0.
  - o_clk_en is forced 0 while i_rst is high.
- Button path, per button:
  - 2-flop synchronizer, then a stability counter.
  - The debounced level takes the synchronized value after DEBOUNCE_CYCLES consecutive identical samples that differ from the current debounced level. Any differing sample restarts the count.
  - A debounced rising edge produces a 1-cycle press pulse.
  - Press latency from a clean raw edge: 2 + DEBOUNCE_CYCLES cycles.
  - Falling edges produce nothing.
- bp_match = i_bp_en && (i_pc_f == i_bp_addr) && !suppress. Combinational.
- o_clk_en is Mealy:
  - 1 when state==RUN && !bp_match.
  - 1 when state==STEP.
  - 0 otherwise.
  - On a match the PC therefore never advances past i_bp_addr.
- Transitions, evaluated per cycle in priority order:
  1. i_halt_req in RUN or STEP -> HALT. This aborts any remaining steps. i_halt_req is ignored in HALT and BP.
  2. Run press:
     - RUN -> HALT.
     - STEP -> HALT (abort).
     - HALT or BP -> RUN; sets suppress=1 and clears o_bp_hit.
  3. Step press in HALT or BP:
     - Load counter = (i_step_count==0 ? 1 : i_step_count).
     - Go to STEP; clear o_bp_hit.
     - Step press in RUN or STEP is ignored.
  4. RUN with bp_match -> BP; set o_bp_hit.
  5. STEP: decrement counter each cycle. When counter==1, next state is HALT. Exactly N enabled cycles occur. Breakpoints are ignored in STEP.
- Simultaneous run and step press: run wins, step is dropped.
- suppress clears after the first cycle in RUN with o_clk_en=1. This lets a resume from BP move off the breakpoint PC.
- o_cycle_cnt increments when o_clk_en=1 and wraps from 0xFFFFFFFF to 0.
- Reset mid-STEP or mid-RUN returns to HALT immediately; no partial step survives.
- i_bp_addr/i_bp_en changes take effect in the same cycle (combinational compare).

Decomposition:
- Shared package: the 2-bit state encodings (ST_HALT, ST_RUN, ST_STEP, ST_BP) and the 0-to-1 step-count rule constant, so the hazard and debug logic can decode o_state.
- Sub-module btn_debounce (synchronizer + stability counter + rising-edge pulse), parameterized by DEBOUNCE_CYCLES and instantiated twice.
- The FSM, step counter, breakpoint compare and cycle counter stay in pipeline_run_ctl.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset, then a clean i_btn_run high for 10 cycles -> o_state=RUN exactly 6 cycles after the raw edge; o_clk_en=1 from that cycle; o_cycle_cnt counts 1,2,3…
- Bounce i_btn_step 0/1/0/1 at 1-cycle spacing, then hold high; i_step_count=3, from HALT -> single STEP entry; o_clk_en high exactly 3 cycles; o_cycle_cnt +3; return to HALT.
- RUN with i_bp_en=1, i_bp_addr=0x40, i_pc_f ramping 0x3C→0x40 -> o_clk_en=0 in the same cycle i_pc_f=0x40; o_state=BP next cycle; o_bp_hit=1.
- From BP, run press with i_pc_f still 0x40 -> RUN; o_clk_en=1 for the first cycle (suppress); o_bp_hit=0; hitting 0x40 again re-enters BP.
- i_step_count=0 step press -> one enabled cycle. i_step_count=200 with i_halt_req pulsed at step 5 -> HALT after 5 enabled cycles.
- Run and step pressed in the same debounced cycle from HALT -> RUN. Assert i_rst during RUN -> o_clk_en=0 during reset; after reset state=HALT, o_cycle_cnt=0.
